id_ex_stage: RTL and testbench

//   ID/EX pipeline boundary of the 5-stage MIPS core. Consumes the register-file read data
//   (rs/rt) and the decoded ID instruction, applies MEM->ID forwarding, detects hazards

---
 rtl/mips_pkg.sv | 34 +++
 rtl/instr_dst_decode.sv | 78 +++++++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, register index type, ID/EX bundle.
// Imported by every pipeline-stage module of the core.
package mips_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam reg_idx_t    RA_REG    = 5'd31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_sext;
    reg_idx_t    wa;
    logic        regwrite;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_dst_decode.sv
// Destination and source-use decode of one instruction word.
// Pure combinational; used for both the ID and the EX slot.
module instr_dst_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output reg_idx_t    wa_o,
  output logic        regwrite_o,
  output logic        uses_rs_o,
  output logic        uses_rt_o,
  output logic        is_load_o,
  output logic        reads_in_id_o
);

  logic [5:0] op;
  logic [5:0] fn;
  reg_idx_t   rt;
  reg_idx_t   rd;
  logic       is_nop;
  logic       is_jr;
  logic       is_alu_r;
  logic       unused_bits;

  assign op       = instr_i[31:26];
  assign fn       = instr_i[5:0];
  assign rt       = instr_i[20:16];
  assign rd       = instr_i[15:11];
  assign is_nop   = (instr_i == NOP_INSTR);
  assign is_jr    = (op == OP_RTYPE) && (fn == FN_JR);
  assign is_alu_r = (op == OP_RTYPE) && !is_nop && !is_jr;

  assign unused_bits = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    wa_o          = '0;
    uses_rs_o     = 1'b0;
    uses_rt_o     = 1'b0;
    is_load_o     = 1'b0;
    reads_in_id_o = 1'b0;
    unique case (1'b1)
      is_nop: ;
      is_jr: begin
        uses_rs_o     = 1'b1;
        reads_in_id_o = 1'b1;
      end
      is_alu_r: begin
        wa_o      = rd;
        uses_rs_o = 1'b1;
        uses_rt_o = 1'b1;
      end
      (op == OP_LW): begin
        wa_o      = rt;
        uses_rs_o = 1'b1;
        is_load_o = 1'b1;
      end
      (op == OP_SW): begin
        uses_rs_o = 1'b1;
        uses_rt_o = 1'b1;
      end
      (op == OP_BEQ): begin
        uses_rs_o     = 1'b1;
        uses_rt_o     = 1'b1;
        reads_in_id_o = 1'b1;
      end
      (op == OP_ORI),
      (op == OP_ADDIU): begin
        wa_o      = rt;
        uses_rs_o = 1'b1;
      end
      (op == OP_LUI): wa_o = rt;
      (op == OP_JAL): wa_o = RA_REG;
      default: ;
    endcase
  end

  assign regwrite_o = (wa_o != '0);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: MEM->ID forwarding, hazard stall, EX operand register.
// A stall holds IF/ID upstream and loads a bubble into EX.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC4 = 32'h0000_3004,
  parameter bit          FWD_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [4:0]  mem_wa,
  input  logic        mem_regwrite,
  input  logic        mem_is_load,
  input  logic [31:0] mem_result,
  output logic        stall_o,
  output logic [31:0] id_rs_fwd,
  output logic [31:0] id_rt_fwd,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_sext,
  output logic [4:0]  ex_wa,
  output logic        ex_regwrite
);

  id_ex_t   ex_q;
  id_ex_t   ex_d;
  id_ex_t   bubble;

  reg_idx_t rs;
  reg_idx_t rt;
  reg_idx_t id_wa;
  logic     id_rw;
  logic     id_urs;
  logic     id_urt;
  logic     id_br;
  logic     ex_load;

  logic     unused_id_load;
  reg_idx_t unused_ex_wa;
  logic     unused_ex_rw;
  logic     unused_ex_urs;
  logic     unused_ex_urt;
  logic     unused_ex_br;

  instr_dst_decode u_id_dec (
    .instr_i       (id_instr),
    .wa_o          (id_wa),
    .regwrite_o    (id_rw),
    .uses_rs_o     (id_urs),
    .uses_rt_o     (id_urt),
    .is_load_o     (unused_id_load),
    .reads_in_id_o (id_br)
  );

  instr_dst_decode u_ex_dec (
    .instr_i       (ex_q.instr),
    .wa_o          (unused_ex_wa),
    .regwrite_o    (unused_ex_rw),
    .uses_rs_o     (unused_ex_urs),
    .uses_rt_o     (unused_ex_urt),
    .is_load_o     (ex_load),
    .reads_in_id_o (unused_ex_br)
  );

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];

  // Loads are excluded: their data only exists after MEM.
  logic fwd_ok;
  assign fwd_ok = FWD_EN && mem_regwrite && !mem_is_load
               && (mem_wa != '0);

  assign id_rs_fwd = (fwd_ok && mem_wa == rs) ? mem_result : id_rs_data;
  assign id_rt_fwd = (fwd_ok && mem_wa == rt) ? mem_result : id_rt_data;

  logic rs_live;
  logic rt_live;
  logic hit_ex;
  logic hit_mem;

  assign rs_live = id_urs && (rs != '0);
  assign rt_live = id_urt && (rt != '0);

  assign hit_ex = ex_q.regwrite
               && ((rs_live && ex_q.wa == rs)
                || (rt_live && ex_q.wa == rt));

  assign hit_mem = mem_regwrite
                && ((rs_live && mem_wa == rs)
                 || (rt_live && mem_wa == rt));

  assign stall_o = (ex_load && hit_ex)
                || (id_br && hit_ex)
                || (id_br && mem_is_load && hit_mem)
                || (!FWD_EN && hit_mem);

  always_comb begin
    bubble     = '0;
    bubble.pc4 = RESET_PC4;
    ex_d       = bubble;
    if (!stall_o) begin
      ex_d.instr    = id_instr;
      ex_d.pc4      = id_pc4;
      ex_d.rs_data  = id_rs_fwd;
      ex_d.rt_data  = id_rt_fwd;
      ex_d.imm_sext = sext16(id_instr[15:0]);
      ex_d.wa       = id_wa;
      ex_d.regwrite = id_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= bubble;
    else       ex_q <= ex_d;
  end

  assign ex_instr    = ex_q.instr;
  assign ex_pc4      = ex_q.pc4;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm_sext = ex_q.imm_sext;
  assign ex_wa       = ex_q.wa;
  assign ex_regwrite = ex_q.regwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, hand sequences, random vs model.
// Instance 0 forwards, instance 1 is built with forwarding disabled.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] id_instr, id_pc4, id_rs_data, id_rt_data, mem_result;
  logic [4:0]  mem_wa;
  logic        mem_regwrite, mem_is_load;

  logic        stall_w [2];
  logic [31:0] rsf_w [2];
  logic [31:0] rtf_w [2];
  logic [31:0] ei_w [2];
  logic [31:0] ep_w [2];
  logic [31:0] ers_w [2];
  logic [31:0] ert_w [2];
  logic [31:0] eim_w [2];
  logic [4:0]  ewa_w [2];
  logic        erw_w [2];

  id_ex_stage #(.RESET_PC4(32'h0000_3004), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .mem_wa(mem_wa), .mem_regwrite(mem_regwrite),
    .mem_is_load(mem_is_load), .mem_result(mem_result),
    .stall_o(stall_w[0]), .id_rs_fwd(rsf_w[0]), .id_rt_fwd(rtf_w[0]),
    .ex_instr(ei_w[0]), .ex_pc4(ep_w[0]), .ex_rs_data(ers_w[0]),
    .ex_rt_data(ert_w[0]), .ex_imm_sext(eim_w[0]), .ex_wa(ewa_w[0]),
    .ex_regwrite(erw_w[0])
  );

  id_ex_stage #(.RESET_PC4(32'h0000_3004), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .mem_wa(mem_wa), .mem_regwrite(mem_regwrite),
    .mem_is_load(mem_is_load), .mem_result(mem_result),
    .stall_o(stall_w[1]), .id_rs_fwd(rsf_w[1]), .id_rt_fwd(rtf_w[1]),
    .ex_instr(ei_w[1]), .ex_pc4(ep_w[1]), .ex_rs_data(ers_w[1]),
    .ex_rt_data(ert_w[1]), .ex_imm_sext(eim_w[1]), .ex_wa(ewa_w[1]),
    .ex_regwrite(erw_w[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mem();
    mem_wa = '0; mem_regwrite = 1'b0; mem_is_load = 1'b0; mem_result = '0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr, pc4, rs, rt, imm;
    logic [4:0]  wa;
  } ex_m_t;

  ex_m_t m [2];

  function automatic ex_m_t m_bubble();
    ex_m_t b;
    b = '0;
    b.pc4 = 32'h0000_3004;
    return b;
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (i == 32'h0) return 5'd0;
    if (op == 6'h00) return (i[5:0] == 6'h08) ? 5'd0 : i[15:11];
    if (op == 6'h23 || op == 6'h0d || op == 6'h0f || op == 6'h09)
      return i[20:16];
    if (op == 6'h03) return 5'd31;
    return 5'd0;
  endfunction

  // {first source, second source}; 0 means no source in that slot
  function automatic logic [9:0] m_srcs(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (i == 32'h0) return '0;
    if (op == 6'h00)
      return (i[5:0] == 6'h08) ? {i[25:21], 5'd0} : {i[25:21], i[20:16]};
    if (op == 6'h23 || op == 6'h0d || op == 6'h09) return {i[25:21], 5'd0};
    if (op == 6'h2b || op == 6'h04) return {i[25:21], i[20:16]};
    return '0;
  endfunction

  function automatic logic m_is_branch(input logic [31:0] i);
    return (i[31:26] == 6'h04) || (i[31:26] == 6'h00 && i[5:0] == 6'h08);
  endfunction

  function automatic logic [31:0] m_fwd(input int k, input logic [4:0] r,
                                        input logic [31:0] d);
    if (k == 0 && mem_regwrite && !mem_is_load && mem_wa != 0 && mem_wa == r)
      return mem_result;
    return d;
  endfunction

  function automatic logic m_stall(input int k);
    logic [9:0] s;
    logic [4:0] src [2];
    logic br, ex_ld, st;
    s = m_srcs(id_instr);
    src[0] = s[9:5];
    src[1] = s[4:0];
    br = m_is_branch(id_instr);
    ex_ld = (m[k].instr[31:26] == 6'h23);
    st = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (src[j] != 0) begin
        if (m[k].wa == src[j] && (ex_ld || br)) st = 1'b1;
        if (mem_regwrite && mem_wa == src[j] && ((br && mem_is_load) || k == 1))
          st = 1'b1;
      end
    end
    return st;
  endfunction

  function automatic ex_m_t m_next(input int k);
    ex_m_t n;
    n = m_bubble();
    if (reset || m_stall(k)) return n;
    n.instr = id_instr;
    n.pc4   = id_pc4;
    n.rs    = m_fwd(k, id_instr[25:21], id_rs_data);
    n.rt    = m_fwd(k, id_instr[20:16], id_rt_data);
    n.imm   = 32'($signed(id_instr[15:0]));
    n.wa    = m_dest(id_instr);
    return n;
  endfunction

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [15:0] imm;
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1:    return {6'h00, rr(), rr(), rr(), 5'd0, 6'h21};
      2:       return {6'h00, rr(), 15'd0, 6'h08};
      3:       return {6'h23, rr(), rr(), imm};
      4:       return {6'h2b, rr(), rr(), imm};
      5:       return {6'h04, rr(), rr(), imm};
      6:       return {6'h0d, rr(), rr(), imm};
      7:       return {6'h0f, 5'd0, rr(), imm};
      8:       return {6'h03, 26'($urandom)};
      9:       return {6'h09, rr(), rr(), imm};
      10:      return 32'h0;
      default: return {6'h02, 26'($urandom)};
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [31:0] pre;
    logic [31:0] id;
    logic [4:0]  mwa;
    logic        mrw;
    logic        mld;
    logic [31:0] mres;
    logic        st;
    logic        st_nf;
    logic [31:0] rsf;
    logic [31:0] rtf;
  } vec_t;

  localparam logic [31:0] RSD = 32'h1111_1111;
  localparam logic [31:0] RTD = 32'h2222_2222;

  vec_t vt [14];
  ex_m_t nxt [2];

  initial begin
    vt[0]  = '{32'h8C08_0000, 32'h010A_4821, 5'd0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, RSD,           RTD};
    vt[1]  = '{32'h0,         32'h10A0_0004, 5'd5,  1'b1, 1'b0, 32'h1234,      1'b0, 1'b1, 32'h1234,      RTD};
    vt[2]  = '{32'h0022_2021, 32'h1084_0000, 5'd0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, RSD,           RTD};
    vt[3]  = '{32'h0,         32'h0000_4821, 5'd0,  1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, RSD,           RTD};
    vt[4]  = '{32'h0,         32'h010A_4821, 5'd8,  1'b1, 1'b1, 32'hDEAD,      1'b0, 1'b1, RSD,           RTD};
    vt[5]  = '{32'h0,         32'h1100_0000, 5'd8,  1'b1, 1'b1, 32'hDEAD,      1'b1, 1'b1, RSD,           RTD};
    vt[6]  = '{32'h0C00_0010, 32'h03E0_0008, 5'd0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, RSD,           RTD};
    vt[7]  = '{32'h0,         32'h03E0_0008, 5'd31, 1'b1, 1'b0, 32'h400,       1'b0, 1'b1, 32'h400,       RTD};
    vt[8]  = '{32'h8C08_0000, 32'h3C08_1234, 5'd0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, RSD,           RTD};
    vt[9]  = '{32'h0022_2021, 32'h0084_4821, 5'd0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, RSD,           RTD};
    vt[10] = '{32'h0,         32'h0063_4821, 5'd3,  1'b1, 1'b0, 32'h77,        1'b0, 1'b1, 32'h77,        32'h77};
    vt[11] = '{32'h0,         32'hAC43_0004, 5'd3,  1'b1, 1'b0, 32'h99,        1'b0, 1'b1, RSD,           32'h99};
    vt[12] = '{32'h8C08_0000, 32'h0100_0008, 5'd0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, RSD,           RTD};
    vt[13] = '{32'h8C08_0000, 32'hAC28_0000, 5'd0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, RSD,           RTD};

    reset = 1'b1;
    id_instr = '0; id_pc4 = '0; id_rs_data = '0; id_rt_data = '0;
    clr_mem();

    // reset state
    tick();
    tick();
    chk("rst ex_instr", ei_w[0], 32'h0);
    chk("rst ex_pc4", ep_w[0], 32'h0000_3004);
    chk("rst ex_regwrite", erw_w[0], 0);
    chk("rst ex_wa", ewa_w[0], 0);
    chk("rst ex_rs", ers_w[0], 0);
    chk("rst ex_imm", eim_w[0], 0);
    chk("rst stall", stall_w[0], 0);

    // table: prime EX with pre, then present the ID/MEM pattern
    for (int i = 0; i < 14; i++) begin
      reset = 1'b1; clr_mem(); id_instr = '0;
      tick();
      reset = 1'b0; id_instr = vt[i].pre;
      tick();
      id_instr = vt[i].id; id_rs_data = RSD; id_rt_data = RTD;
      mem_wa = vt[i].mwa; mem_regwrite = vt[i].mrw;
      mem_is_load = vt[i].mld; mem_result = vt[i].mres;
      #1;
      chk($sformatf("vec%0d stall", i), stall_w[0], vt[i].st);
      chk($sformatf("vec%0d stall_nofwd", i), stall_w[1], vt[i].st_nf);
      chk($sformatf("vec%0d rs_fwd", i), rsf_w[0], vt[i].rsf);
      chk($sformatf("vec%0d rt_fwd", i), rtf_w[0], vt[i].rtf);
    end

    // load-use: one stall, bubble, then addu enters EX
    reset = 1'b1; clr_mem(); tick(); reset = 1'b0;
    id_instr = 32'h8C08_0000; id_pc4 = 32'h200;
    tick();
    id_instr = 32'h010A_4821; id_pc4 = 32'h204; id_rs_data = 32'hA5;
    #1 chk("lu stall", stall_w[0], 1);
    tick();
    chk("lu bubble instr", ei_w[0], 0);
    chk("lu bubble pc4", ep_w[0], 32'h3004);
    chk("lu bubble wa", ewa_w[0], 0);
    mem_wa = 5'd8; mem_regwrite = 1'b1; mem_is_load = 1'b1;
    mem_result = 32'hBAD;
    #1 chk("lu stall clear", stall_w[0], 0);
    tick();
    chk("lu ex_instr", ei_w[0], 32'h010A_4821);
    chk("lu ex_pc4", ep_w[0], 32'h204);
    chk("lu ex_wa", ewa_w[0], 9);
    chk("lu ex_regwrite", erw_w[0], 1);
    chk("lu ex_rs", ers_w[0], 32'hA5);
    chk("lu ex_imm", eim_w[0], 32'h0000_4821);

    // beq on EX producer: stall, then MEM forwarding clears it
    reset = 1'b1; clr_mem(); tick(); reset = 1'b0;
    id_instr = 32'h0022_2021; id_pc4 = 32'h100;
    tick();
    id_instr = 32'h1084_FFFC; id_pc4 = 32'h104;
    id_rs_data = 32'h1; id_rt_data = 32'h2;
    #1 chk("br stall", stall_w[0], 1);
    tick();
    chk("br bubble instr", ei_w[0], 0);
    mem_wa = 5'd4; mem_regwrite = 1'b1; mem_result = 32'hCAFE;
    #1;
    chk("br stall clear", stall_w[0], 0);
    chk("br rs_fwd", rsf_w[0], 32'hCAFE);
    chk("br rt_fwd", rtf_w[0], 32'hCAFE);
    tick();
    chk("br ex_instr", ei_w[0], 32'h1084_FFFC);
    chk("br ex_rs", ers_w[0], 32'hCAFE);
    chk("br ex_rt", ert_w[0], 32'hCAFE);
    chk("br ex_imm", eim_w[0], 32'hFFFF_FFFC);
    chk("br ex_regwrite", erw_w[0], 0);

    // reset while stalled
    reset = 1'b1; clr_mem(); tick(); reset = 1'b0;
    id_instr = 32'h8C08_0000;
    tick();
    id_instr = 32'h010A_4821;
    #1 chk("rs stall", stall_w[0], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rs ex_wa", ewa_w[0], 0);
    chk("rs ex_instr", ei_w[0], 0);
    chk("rs stall after", stall_w[0], 0);

    // randomized run against the model
    reset = 1'b1; clr_mem(); tick(); reset = 1'b0;
    m[0] = m_bubble();
    m[1] = m_bubble();
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 39) == 0);
      id_instr     = rnd_instr();
      id_pc4       = $urandom;
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      mem_wa       = rr();
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_is_load  = ($urandom_range(0, 3) == 0);
      mem_result   = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d d%0d stall", n, k), stall_w[k], m_stall(k));
        chk($sformatf("rnd%0d d%0d rs_fwd", n, k), rsf_w[k],
            m_fwd(k, id_instr[25:21], id_rs_data));
        chk($sformatf("rnd%0d d%0d rt_fwd", n, k), rtf_w[k],
            m_fwd(k, id_instr[20:16], id_rt_data));
        nxt[k] = m_next(k);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        m[k] = nxt[k];
        chk($sformatf("rnd%0d d%0d ex_instr", n, k), ei_w[k], m[k].instr);
        chk($sformatf("rnd%0d d%0d ex_pc4", n, k), ep_w[k], m[k].pc4);
        chk($sformatf("rnd%0d d%0d ex_rs", n, k), ers_w[k], m[k].rs);
        chk($sformatf("rnd%0d d%0d ex_rt", n, k), ert_w[k], m[k].rt);
        chk($sformatf("rnd%0d d%0d ex_imm", n, k), eim_w[k], m[k].imm);
        chk($sformatf("rnd%0d d%0d ex_wa", n, k), ewa_w[k], m[k].wa);
        chk($sformatf("rnd%0d d%0d ex_rw", n, k), erw_w[k], m[k].wa != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
